// File: rtl/mem_stage_unit_pkg.sv
// Shared MEM-stage definitions: control bit positions, FSM encoding and op decode.
package mem_stage_unit_pkg;

  localparam int unsigned WB_REGWRITE  = 1;
  localparam int unsigned WB_MEMTOREG  = 0;
  localparam int unsigned MEM_MEMREAD  = 1;
  localparam int unsigned MEM_MEMWRITE = 0;

  localparam int unsigned TMR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_READ,
    OP_WRITE,
    OP_ILLEGAL
  } mem_op_e;

  function automatic mem_op_e decode_op(input logic [1:0] mem);
    mem_op_e op;
    if (mem[MEM_MEMREAD] && mem[MEM_MEMWRITE]) begin
      op = OP_ILLEGAL;
    end else if (mem[MEM_MEMREAD]) begin
      op = OP_READ;
    end else if (mem[MEM_MEMWRITE]) begin
      op = OP_WRITE;
    end else begin
      op = OP_NONE;
    end
    return op;
  endfunction

endpackage

// File: rtl/mem_stage_unit_timer.sv
// Wait counter for an outstanding data-memory request; flags the cycle whose
// increment would reach TIMEOUT.
module mem_wait_timer
  import mem_stage_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_stage_unit.sv
// MEM-stage access controller: runs a req/ack transaction on the data memory,
// stalls upstream while it is outstanding and presents the MEM/WB bundle.
module mem_stage_unit
  import mem_stage_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_in,
  input  logic [1:0]  mem_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] rd2_in,
  input  logic [4:0]  wn_in,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic        mw_en,
  output logic [1:0]  mw_wb,
  output logic [31:0] mw_rdata,
  output logic [31:0] mw_alu,
  output logic [4:0]  mw_wn,
  output logic        align_err,
  output logic        bus_err
);

  mem_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic        bus_err_q, bus_err_d;

  logic        tmr_clr, tmr_inc, tmr_expire;
  mem_op_e     op;
  logic        is_access;
  logic        misaligned;

  assign op         = decode_op(mem_in);
  assign is_access  = (op == OP_READ) || (op == OP_WRITE);
  assign misaligned = (alu_in[1:0] != 2'b00);

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (tmr_clr),
    .inc_i   (tmr_inc),
    .expire_o(tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    bus_err_d = bus_err_q;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    stall     = 1'b0;
    dm_req    = 1'b0;
    align_err = 1'b0;
    mw_wb     = wb_in;
    mw_rdata  = '0;

    case (state_q)
      ST_IDLE: begin
        if (op == OP_ILLEGAL) begin
          align_err = 1'b1;
        end else if (is_access) begin
          if (misaligned) begin
            align_err = 1'b1;
            mw_wb     = '0;
          end else begin
            stall   = 1'b1;
            we_d    = (op == OP_WRITE);
            addr_d  = alu_in;
            wdata_d = rd2_in;
            rdata_d = '0;
            fault_d = 1'b0;
            tmr_clr = 1'b1;
            state_d = ST_ACCESS;
          end
        end
      end

      ST_ACCESS: begin
        dm_req = 1'b1;
        stall  = 1'b1;
        // Ack wins over expiry so a last-cycle ack still counts as success.
        if (dm_ack) begin
          rdata_d = we_q ? '0 : dm_rdata;
          state_d = ST_DONE;
        end else if (tmr_expire) begin
          bus_err_d = 1'b1;
          rdata_d   = '0;
          fault_d   = 1'b1;
          state_d   = ST_DONE;
        end else begin
          tmr_inc = 1'b1;
        end
      end

      ST_DONE: begin
        mw_rdata = rdata_q;
        if (fault_q) begin
          mw_wb = '0;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      fault_q   <= fault_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign dm_we    = we_q;
  assign dm_addr  = addr_q;
  assign dm_wdata = wdata_q;
  assign bus_err  = bus_err_q;
  assign mw_en    = ~stall;
  assign mw_alu   = alu_in;
  assign mw_wn    = wn_in;

endmodule

// File: doc/mem_stage_unit.md
# mem_stage_unit

MEM-stage access controller sitting between the EX/MEM pipeline register outputs and the data-memory bus. It turns the latched MemRead/MemWrite control, ALU address and store data into a request/acknowledge transaction on a variable-latency data memory. While the access is outstanding it stalls the upstream pipeline. It hands the completed result bundle (load data, ALU result, WB control, write-register number) to the MEM/WB register through a single enable.

## Interface
- `TIMEOUT`, default 255: cycles `dm_req` may wait for `dm_ack` before the access is aborted; legal range 1..255.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `wb_in` in 2: WB control from EX/MEM; [1]=RegWrite, [0]=MemtoReg.
- `mem_in` in 2: MEM control from EX/MEM; [1]=MemRead, [0]=MemWrite.
- `alu_in` in 32: ALU result, used as byte address.
- `rd2_in` in 32: store data.
- `wn_in` in 5: destination register number.
- `dm_req` out 1: memory request.
- `dm_we` out 1: 1=write, 0=read.
- `dm_addr` out 32: request address.
- `dm_wdata` out 32: write data.
- `dm_ack` in 1: memory completion, one-cycle pulse.
- `dm_rdata` in 32: read data, valid when `dm_ack`=1.
- `stall` out 1: hold PC/IF_ID/ID_EX/EX_MEM; drives their `en_reg` low.
- `mw_en` out 1: MEM/WB load enable, equal to ~`stall`.
- `mw_wb` out 2: WB control to MEM/WB.
- `mw_rdata` out 32: load data to MEM/WB.
- `mw_alu` out 32: ALU result pass-through, equal to `alu_in`.
- `mw_wn` out 5: equal to `wn_in`.
- `align_err` out 1: one-cycle pulse on a misaligned access.
- `bus_err` out 1: sticky timeout flag, cleared only by `rst`.

## Operation
- **Access condition:** `mem_in`=2'b10 is a read and 2'b01 is a write. 2'b00 is no memory op. 2'b11 is illegal and is treated as a no-op that also pulses `align_err`.
- **FSM states:** IDLE, ACCESS, DONE.
- **IDLE, no-op:** `stall`=0. `mw_rdata`=0. `mw_wb`=`wb_in`. The instruction passes in one cycle.
- **IDLE, misaligned access** (`alu_in[1:0]`≠0): no request is issued. `stall`=0. `align_err` pulses. `mw_wb` is forced to 2'b00. `mw_rdata`=0.
- **IDLE, aligned access:** `stall`=1 combinationally. The block captures `alu_in`, `rd2_in` and the write flag into `dm_addr`/`dm_wdata`/`dm_we`, clears the wait counter, and moves to ACCESS.
- **ACCESS:** `dm_req`=1 and `stall`=1.
  - `dm_req`, `dm_we`, `dm_addr` and `dm_wdata` stay stable until the ack.
  - On `dm_ack`: latch `dm_rdata` (reads only; writes latch 0), then move to DONE.
  - Otherwise the counter increments. When it reaches `TIMEOUT`: set `bus_err`, latch 0, mark the access faulted, and move to DONE.
- **DONE:** `dm_req`=0 and `stall`=0, so `mw_en`=1.
  - `mw_rdata` is the latched value.
  - `mw_wb`=`wb_in`, or 2'b00 if the access faulted.
  - Next state is IDLE.
- An ack outside ACCESS is ignored.

## Timing
- **Reset values:** state IDLE. `dm_req`, `dm_we`, `dm_addr`, `dm_wdata`, `bus_err`, `align_err` and the latched data are all 0. `stall` and `mw_*` follow the IDLE rules.
- **Latency:**
  - A non-memory op takes 1 cycle.
  - A memory op takes 2+N cycles, where N is the number of ACCESS cycles (≥1) up to and including the ack cycle.
  - Minimum: 3 cycles with 2 stall cycles.
- **Input stability:** EX/MEM contents hold throughout IDLE(stalled)/ACCESS/DONE and advance only at the end of DONE. Back-to-back memory ops therefore restart in IDLE.
- **Ack timing:** an ack arriving in the same cycle the counter reaches `TIMEOUT` counts as success, and `bus_err` is not set.
- **Reset during ACCESS:** the FSM returns to IDLE and `dm_req` deasserts on the next edge. The memory must tolerate an abandoned request.
- **`bus_err`:** stays set through subsequent successful accesses until `rst`.

## Structure
- **Shared pipeline package:**
  - WB/MEM bit positions (REGWRITE=1, MEMTOREG=0, MEMREAD=1, MEMWRITE=0).
  - State encoding: IDLE=2'd0, ACCESS=2'd1, DONE=2'd2.
- **Sub-module:** `mem_wait_timer`, an 8-bit clear/increment counter with a compare against `TIMEOUT`. Everything else is flat.

## Test plan
- **Non-memory op:** `mem_in`=00, `wb_in`=10, `alu_in`=0x1234 → `stall`=0, `mw_en`=1, `mw_alu`=0x1234, `mw_wb`=10 in the same cycle.
- **Load with 3-cycle ack delay:** read at 0x100, `dm_ack` on the 3rd ACCESS cycle with `dm_rdata`=0xCAFEF00D → `dm_req` high for exactly 3 cycles, `stall` high for 4, `mw_rdata`=0xCAFEF00D in DONE.
- **Store with immediate ack:** write 0x55AA55AA to 0x200 → `dm_we`=1, address and data stable while `dm_req`=1, total 3 cycles, `mw_rdata`=0.
- **Misaligned read:** read at 0x102 → no `dm_req`, `align_err` pulses 1 cycle, `mw_wb`=00, `stall`=0.
- **Timeout:** `TIMEOUT`=4, never ack → `dm_req` drops after 4 ACCESS cycles, `bus_err`=1 and stays set, `mw_wb`=00. A following good load completes normally.
- **Reset mid-ACCESS:** assert `rst` on the 2nd ACCESS cycle → next cycle state IDLE, `dm_req`=0, `stall` follows the current inputs.
